// File: rtl/led_pattern_sequencer_if.sv
// Control and display signals of the LED pattern sequencer.
// master drives the controls, slave (the sequencer) drives the lights.
interface led_pattern_sequencer_if #(
   parameter int RED_W   = 10,
   parameter int GREEN_W = 8
);
   logic               en;
   logic               step;
   logic [1:0]         mode;
   logic [1:0]         speed;
   logic [RED_W-1:0]   red_lights;
   logic [GREEN_W-1:0] green_lights;
   logic               tick;
   logic [1:0]         cur_mode;

   modport master (
      output en, step, mode, speed,
      input  red_lights, green_lights, tick, cur_mode
   );

   modport slave (
      input  en, step, mode, speed,
      output red_lights, green_lights, tick, cur_mode
   );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Timed LED pattern generator (ALT/CHASE/BOUNCE/BLINK) with free-run divider or manual step.
// Latency: all outputs registered, new pattern and tick appear on the advancing edge; no backpressure.
module led_pattern_sequencer #(
   parameter int DIV     = 10000000,
   parameter int RED_W   = 10,
   parameter int GREEN_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   led_pattern_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      MODE_ALT    = 2'b00,
      MODE_CHASE  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Largest period is DIV << 3; four extra bits cover it including the equality case.
   localparam int CNT_W = $clog2(DIV) + 4;

   localparam logic [2*RED_W-1:0]   RED_REP = {RED_W{2'b10}};
   localparam logic [2*GREEN_W-1:0] GRN_REP = {GREEN_W{2'b10}};
   localparam logic [RED_W-1:0]     RED_ALT = RED_REP[2*RED_W-1 -: RED_W];
   localparam logic [GREEN_W-1:0]   GRN_ALT = GRN_REP[2*GREEN_W-1 -: GREEN_W];
   localparam logic [RED_W-1:0]     RED_MSB = {1'b1, {(RED_W-1){1'b0}}};

   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               step_q,     step_d;
   logic               tick_q,     tick_d;
   logic [RED_W-1:0]   red_q,      red_d;
   logic [GREEN_W-1:0] green_q,    green_d;
   logic [GREEN_W-1:0] step_cnt_q, step_cnt_d;
   mode_e              mode_q,     mode_d;
   dir_e               dir_q,      dir_d;

   logic [CNT_W-1:0]   period;
   logic               adv;
   mode_e              req_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         step_q     <= 1'b0;
         tick_q     <= 1'b0;
         red_q      <= RED_ALT;
         green_q    <= GRN_ALT;
         step_cnt_q <= '0;
         mode_q     <= MODE_ALT;
         dir_q      <= DIR_DOWN;
      end else begin
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         tick_q     <= tick_d;
         red_q      <= red_d;
         green_q    <= green_d;
         step_cnt_q <= step_cnt_d;
         mode_q     <= mode_d;
         dir_q      <= dir_d;
      end
   end

   // Divider and manual step edge detect; >= lets a shrinking period fire at once.
   always_comb begin
      period = CNT_W'(DIV) << bus.speed;
      adv    = 1'b0;
      cnt_d  = cnt_q;
      step_d = bus.step;
      if (bus.en) begin
         if (cnt_q >= period - CNT_W'(1)) begin
            cnt_d = '0;
            adv   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
         adv   = bus.step & ~step_q;
      end
      tick_d = adv;
   end

   always_comb begin
      red_d      = red_q;
      green_d    = green_q;
      step_cnt_d = step_cnt_q;
      mode_d     = mode_q;
      dir_d      = dir_q;
      req_mode   = mode_e'(bus.mode);
      if (adv) begin
         if (req_mode != mode_q) begin
            // A mode switch only loads the new start pattern; it does not also advance.
            mode_d     = req_mode;
            step_cnt_d = '0;
            dir_d      = DIR_DOWN;
            case (req_mode)
               MODE_ALT: begin
                  red_d   = RED_ALT;
                  green_d = GRN_ALT;
               end
               MODE_CHASE, MODE_BOUNCE: begin
                  red_d   = RED_MSB;
                  green_d = '0;
               end
               default: begin
                  red_d   = '1;
                  green_d = '1;
               end
            endcase
         end else begin
            step_cnt_d = step_cnt_q + GREEN_W'(1);
            case (mode_q)
               MODE_CHASE: begin
                  red_d   = {red_q[0], red_q[RED_W-1:1]};
                  green_d = step_cnt_d;
               end
               MODE_BOUNCE: begin
                  // Flip direction as the endpoint is reached so it shows for one tick only.
                  if (dir_q == DIR_DOWN) begin
                     red_d = red_q >> 1;
                     if (red_q[1]) dir_d = DIR_UP;
                  end else begin
                     red_d = red_q << 1;
                     if (red_q[RED_W-2]) dir_d = DIR_DOWN;
                  end
                  green_d = step_cnt_d;
               end
               default: begin
                  red_d   = ~red_q;
                  green_d = ~green_q;
               end
            endcase
         end
      end
   end

   assign bus.red_lights   = red_q;
   assign bus.green_lights = green_q;
   assign bus.tick         = tick_q;
   assign bus.cur_mode     = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomized and directed bench for led_pattern_sequencer against a position/phase model.
module tb_led_pattern_sequencer;

   localparam int DIV = 4;
   localparam int RW  = 4;
   localparam int GW  = 4;

   logic clk;
   logic rst_n;

   led_pattern_sequencer_if #(.RED_W(RW), .GREEN_W(GW)) bus ();

   led_pattern_sequencer #(.DIV(DIV), .RED_W(RW), .GREEN_W(GW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: the hot LED is an index from the MSB, ALT/BLINK are a phase bit.
   int m_cnt;
   bit m_step_q;
   int m_mode;
   int m_pos;
   bit m_up;
   bit m_phase;
   int m_green;
   bit m_tick;

   function automatic logic [31:0] alt_pat(input int w, input bit ph);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < w; i++) v[i] = (((w - 1 - i) % 2) == 0) ^ ph;
      return v;
   endfunction

   function automatic logic [31:0] exp_red();
      case (m_mode)
         0:       return alt_pat(RW, m_phase);
         1, 2:    return 32'd1 << (RW - 1 - m_pos);
         default: return m_phase ? 32'd0 : 32'((1 << RW) - 1);
      endcase
   endfunction

   function automatic logic [31:0] exp_green();
      case (m_mode)
         0:       return alt_pat(GW, m_phase);
         1, 2:    return 32'(m_green % (1 << GW));
         default: return m_phase ? 32'd0 : 32'((1 << GW) - 1);
      endcase
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_step_q = 0; m_mode = 0; m_pos = 0;
      m_up = 0; m_phase = 0; m_green = 0; m_tick = 0;
   endtask

   task automatic model_advance();
      if (int'(bus.mode) != m_mode) begin
         m_mode = int'(bus.mode);
         m_phase = 0; m_pos = 0; m_up = 0; m_green = 0;
      end else begin
         case (m_mode)
            1: begin m_pos = (m_pos + 1) % RW; m_green++; end
            2: begin
               if (!m_up) begin
                  m_pos++;
                  if (m_pos == RW - 1) m_up = 1;
               end else begin
                  m_pos--;
                  if (m_pos == 0) m_up = 0;
               end
               m_green++;
            end
            default: m_phase = ~m_phase;
         endcase
      end
   endtask

   task automatic model_edge();
      bit adv;
      int per;
      if (!rst_n) begin
         model_reset();
         return;
      end
      adv = 0;
      if (bus.en) begin
         per = DIV * (1 << bus.speed);
         if (m_cnt + 1 >= per) begin m_cnt = 0; adv = 1; end
         else m_cnt++;
      end else begin
         m_cnt = 0;
         adv = bus.step && !m_step_q;
      end
      m_step_q = bus.step;
      m_tick = adv;
      if (adv) model_advance();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("red",      32'(bus.red_lights),   exp_red());
      chk("green",    32'(bus.green_lights), exp_green());
      chk("tick",     32'(bus.tick),         32'(m_tick));
      chk("cur_mode", 32'(bus.cur_mode),     32'(m_mode));
   endtask

   // One clock: model follows the edge, outputs compared 1 time unit later, return at negedge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic run_to_tick(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         cycle();
         n++;
         if (m_tick) return;
      end
      n_vec++;
      n_err++;
      $error("FAIL tick_timeout: observed no tick in 200 cycles, expected one");
   endtask

   task automatic async_reset_check();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_red",   32'(bus.red_lights),   32'h0000_000A);
      chk("rst_green", 32'(bus.green_lights), 32'h0000_000A);
      chk("rst_mode",  32'(bus.cur_mode),     32'd0);
      chk("rst_tick",  32'(bus.tick),         32'd0);
   endtask

   logic [3:0] chase_red [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
   logic [3:0] bounce_red [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0100};

   initial begin
      int n;
      int ticks;
      int r;
      bus.en = 1'b1; bus.step = 1'b0; bus.mode = 2'b00; bus.speed = 2'b00;
      rst_n = 1'b1;
      @(negedge clk);
      async_reset_check();
      cycle();
      cycle();
      rst_n = 1'b1;

      // ALT free-running: three ticks in twelve edges.
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (bus.tick) ticks++;
      end
      chk("alt_ticks", 32'(ticks), 32'd3);

      // CHASE sequence.
      bus.mode = 2'b01;
      for (int i = 0; i < 5; i++) begin
         run_to_tick(n);
         chk("chase_red",   32'(bus.red_lights),   32'(chase_red[i]));
         chk("chase_green", 32'(bus.green_lights), 32'(i));
      end
      chk("chase_mode", 32'(bus.cur_mode), 32'd1);

      // BOUNCE sequence.
      bus.mode = 2'b10;
      for (int i = 0; i < 8; i++) begin
         run_to_tick(n);
         chk("bounce_red", 32'(bus.red_lights), 32'(bounce_red[i]));
      end

      // Manual stepping: held step advances once.
      bus.en = 1'b0;
      cycle();
      bus.step = 1'b1;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin cycle(); if (bus.tick) ticks++; end
      chk("step_held", 32'(ticks), 32'd1);
      bus.step = 1'b0;
      cycle();
      cycle();
      bus.step = 1'b1;
      ticks = 0;
      for (int i = 0; i < 4; i++) begin cycle(); if (bus.tick) ticks++; end
      chk("step_again", 32'(ticks), 32'd1);
      bus.step = 1'b0;

      // Speed change: period 16, then shrink mid-count.
      bus.speed = 2'd2;
      bus.en = 1'b1;
      run_to_tick(n);
      chk("period16", 32'(n), 32'd16);
      for (int i = 0; i < 10; i++) cycle();
      bus.speed = 2'd0;
      cycle();
      chk("shrink_tick", 32'(bus.tick), 32'd1);
      run_to_tick(n);
      chk("period4", 32'(n), 32'd4);

      // Asynchronous reset mid-CHASE.
      bus.mode = 2'b01;
      run_to_tick(n);
      run_to_tick(n);
      cycle();
      cycle();
      async_reset_check();
      cycle();
      rst_n = 1'b1;
      run_to_tick(n);
      chk("post_rst_period", 32'(n), 32'd4);

      // Randomized operation.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 199));
         if (r < 4) bus.en = ~bus.en;
         if (r < 60) bus.step = 1'($urandom_range(0, 1));
         if (r >= 190) bus.mode = 2'($urandom_range(0, 3));
         if (r == 150) bus.speed = 2'($urandom_range(0, 2));
         if (r == 199) begin
            async_reset_check();
            cycle();
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
